switch_port_egress_rx: RTL and testbench
========================================

// Module: switch_port_egress_rx
// PURPOSE
//  Receive-side endpoint for one switch_4port egress port: the consumer of valid_out/source_out/target_out/data_out.
//  Checks each delivered packet, buffers good packets in a FIFO and hands them to the local client on a valid/ready pair.
//  Keeps per-source statistics. One instance sits on each of the 4 switch ports, opposite the ingress packet driver.
// PARAMETERS
//  PORT_ID   0   index (0..3) of the switch port this instance terminates; expected target = 1<<PORT_ID
//  DEPTH     4   FIFO entries; power of 2, >=2
//  DATA_W    8   packet data width
//  CNT_W     16  width of every statistics counter
// PORTS
//  clk          in   1          single clock, all logic on posedge
//  rst          in   1          reset, synchronous, active-high
//  sw_valid     in   1          packet strobe from switch egress (one cycle per packet, no backpressure)
//  sw_source    in   4          one-hot source port of packet
//  sw_target    in   4          one-hot target mask of packet
//  sw_data      in   DATA_W     packet payload
//  rx_valid     out  1          FIFO head valid to client
//  rx_ready     in   1          client accepts head
//  rx_source    out  2          encoded source index of head packet
//  rx_data      out  DATA_W     payload of head packet
//  fifo_level   out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  clr_stats    in   1          synchronous clear of all counters and err_sticky
//  pkt_cnt      out  4*CNT_W    accepted packets per source; slice [i*CNT_W +: CNT_W] = source i
//  drop_cnt     out  CNT_W      good packets lost to FIFO full
//  bad_cnt      out  CNT_W      packets rejected by checks
//  err_sticky   out  1          set on any drop or reject; cleared only by rst/clr_stats
// BEHAVIOUR
//  Reset: rx_valid=0, fifo_level=0, all counters=0, err_sticky=0; rx_source/rx_data=0; pointers=0.
//  Reset asserted mid-stream: FIFO contents are discarded; sw_valid in the reset cycle is ignored.
//  Classification is done each cycle with sw_valid=1, in priority order:
//   1. BAD: sw_target != (1<<PORT_ID), OR sw_source not exactly one-hot, OR sw_source == (1<<PORT_ID)
//      -> not written; bad_cnt++.
//   2. DROP: FIFO full and no pop in the same cycle -> not written; drop_cnt++.
//   3. ACCEPT: written {encode(sw_source), sw_data}; pkt_cnt[src]++.
//  Pop happens when rx_valid && rx_ready.
//  Full + pop + ACCEPT in the same cycle: accepted, level unchanged.
//  Empty + ACCEPT: no bypass. rx_valid rises at the edge that writes, so first data is visible 1 cycle after sw_valid.
//  rx_valid = (level != 0). rx_source/rx_data come straight from the head entry.
//  Head is stable while rx_valid && !rx_ready.
//  Pointers are log2(DEPTH) bits and wrap naturally. level counts +1 on write, -1 on pop, 0 on both.
//  Order: FIFO is strict FIFO, no reordering across sources.
//  Counters saturate at all-ones and never wrap.
//  err_sticky sets on the edge of any BAD or DROP event.
//  clr_stats has priority over a same-cycle increment: the counter reads 0 after the edge and that event is not counted.
//  clr_stats does not touch the FIFO.
//  Pointer state machine per FIFO: EMPTY (level=0) / PARTIAL / FULL (level=DEPTH). Transitions follow the push/pop rules above.
// TESTING
//  T1 PORT_ID=1: sw_valid with src=4'b0001, tgt=4'b0010, data=8'hAA
//     -> next cycle rx_valid=1, rx_source=0, rx_data=AA; pkt_cnt[0]=1.
//  T2 PORT_ID=1: tgt=4'b0100, then src=4'b0011, then src=4'b0010
//     -> 3 rejects, bad_cnt=3, err_sticky=1, rx_valid stays 0.
//  T3 DEPTH=4, rx_ready=0: 6 good packets data 01..06
//     -> level=4, drop_cnt=2; drain returns 01,02,03,04 in order.
//  T4 Full FIFO, rx_ready=1 and good sw_valid (data 55) in the same cycle
//     -> pop head, accept 55, level stays 4, drop_cnt unchanged.
//  T5 Back-to-back 10 packets alternating src 0/2, rx_ready=1
//     -> pkt_cnt[0]=5, pkt_cnt[2]=5, no drops, data order preserved.
//  T6 clr_stats pulsed on the same cycle as a good packet, then rst with level=3
//     -> counters 0 after clr_stats, packet still enqueued; after rst level=0, rx_valid=0.

Source files
------------

// File: rtl/switch_port_egress_rx_if.sv
// ---------------------------------------------------------------------------
// switch_port_egress_rx_if
//   Bundles the two streams around one egress endpoint:
//     sw_*  : packet strobe arriving from the switch egress port. One cycle
//             per packet and no backpressure, so the endpoint must decide on
//             the spot.
//     rx_*  : FIFO head presented to the local client.
//   rx handshake: a transfer happens on a posedge where rx_valid && rx_ready.
//   While rx_valid is high and rx_ready is low, rx_source/rx_data hold steady.
//   rx_valid never depends on rx_ready.
//
//   Modports:
//     master : the environment side (drives sw_*, rx_ready)
//     slave  : the endpoint (consumes sw_*, drives rx_valid/rx_source/rx_data)
// ---------------------------------------------------------------------------
interface switch_port_egress_rx_if #(
    parameter int DATA_W = 8
);
    logic              sw_valid;
    logic [3:0]        sw_source;
    logic [3:0]        sw_target;
    logic [DATA_W-1:0] sw_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [1:0]        rx_source;
    logic [DATA_W-1:0] rx_data;

    modport master (
        output sw_valid, sw_source, sw_target, sw_data, rx_ready,
        input  rx_valid, rx_source, rx_data
    );

    modport slave (
        input  sw_valid, sw_source, sw_target, sw_data, rx_ready,
        output rx_valid, rx_source, rx_data
    );
endinterface

// File: rtl/switch_port_egress_rx.sv
// ---------------------------------------------------------------------------
// switch_port_egress_rx
//   Receive endpoint for one switch_4port egress port. Each packet strobe is
//   classified as BAD (wrong target, source not one-hot, or looped back from
//   this port), DROP (good but FIFO full with no pop this cycle) or ACCEPT
//   (written into the FIFO as {source index, data}). The FIFO head goes to
//   the local client over a valid/ready pair. Per-source accept counters,
//   drop/bad counters and a sticky error flag are kept for software.
//
//   Ports:
//     clk, rst     single clock; synchronous active-high reset
//     bus          switch_port_egress_rx_if.slave (sw_* in, rx_* out)
//     clr_stats    synchronous clear of all counters and err_sticky
//     fifo_level   FIFO occupancy, 0..DEPTH
//     pkt_cnt      accepted packets per source, slice [i*CNT_W +: CNT_W]
//     drop_cnt     good packets lost to a full FIFO
//     bad_cnt      packets rejected by the checks
//     err_sticky   set by any BAD or DROP event
//     fifo_state   pointer state: 0 EMPTY, 1 PARTIAL, 2 FULL
// ---------------------------------------------------------------------------
module switch_port_egress_rx #(
    parameter int PORT_ID = 0,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    switch_port_egress_rx_if.slave    bus,
    input  logic                      clr_stats,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [4*CNT_W-1:0]        pkt_cnt,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic [CNT_W-1:0]          bad_cnt,
    output logic                      err_sticky,
    output logic [1:0]                fifo_state
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + 2;

    localparam logic [3:0]       OWN_MASK = 4'(1 << PORT_ID);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_nxt;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] src_cnt [4];

    logic       src_one_hot;
    logic [1:0] src_idx;
    logic       is_bad;
    logic       is_drop;
    logic       push;
    logic       pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Classification
    // ------------------------------------------------------------------
    always_comb begin
        src_one_hot = $onehot(bus.sw_source);
        src_idx     = 2'd0;
        case (bus.sw_source)
            4'b0010: src_idx = 2'd1;
            4'b0100: src_idx = 2'd2;
            4'b1000: src_idx = 2'd3;
            default: src_idx = 2'd0;
        endcase
    end

    always_comb begin
        pop     = (level != '0) && bus.rx_ready;
        is_bad  = bus.sw_valid &&
                  ((bus.sw_target != OWN_MASK) || !src_one_hot ||
                   (bus.sw_source == OWN_MASK));
        // A same-cycle pop frees the slot, so a full FIFO can still accept.
        is_drop = bus.sw_valid && !is_bad && (level == LVL_FULL) && !pop;
        push    = bus.sw_valid && !is_bad && !is_drop;
    end

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + LVL_W'(1);
            2'b01:   level_nxt = level - LVL_W'(1);
            default: level_nxt = level;
        endcase
        if (level_nxt == '0) begin
            state_nxt = ST_EMPTY;
        end else if (level_nxt == LVL_FULL) begin
            state_nxt = ST_FULL;
        end else begin
            state_nxt = ST_PARTIAL;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            state  <= ST_EMPTY;
            // Cleared so the head reads zero right after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {src_idx, bus.sw_data};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_nxt;
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Statistics; a clear wins over any increment in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            for (int i = 0; i < 4; i++) begin
                src_cnt[i] <= '0;
            end
            drop_cnt   <= '0;
            bad_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (push) begin
                src_cnt[src_idx] <= sat_inc(src_cnt[src_idx]);
            end
            if (is_drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
            if (is_bad) begin
                bad_cnt <= sat_inc(bad_cnt);
            end
            if (is_bad || is_drop) begin
                err_sticky <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rx_valid  = (level != '0);
    assign bus.rx_source = mem[rd_ptr][ENT_W-1 -: 2];
    assign bus.rx_data   = mem[rd_ptr][DATA_W-1:0];
    assign fifo_level    = level;
    assign fifo_state    = state;

    for (genvar g = 0; g < 4; g++) begin : g_pkt_cnt
        assign pkt_cnt[g*CNT_W +: CNT_W] = src_cnt[g];
    end
endmodule

// File: tb/tb_switch_port_egress_rx.sv
// ---------------------------------------------------------------------------
// tb_switch_port_egress_rx
//   Bench for switch_port_egress_rx with PORT_ID=1, DEPTH=4 and a narrow
//   CNT_W so counter saturation is reached quickly. A reference model
//   updates on each posedge from the driven inputs; a monitor on the negedge
//   compares the DUT against it and pops the expected-packet queue whenever
//   the client takes the head.
// ---------------------------------------------------------------------------
module tb_switch_port_egress_rx;
    localparam int PORT_ID = 1;
    localparam int DEPTH   = 4;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;
    localparam int W       = DATA_W + 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [3:0] OWN = 4'b0010;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic clr_stats;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [4*CNT_W-1:0]     pkt_cnt;
    logic [CNT_W-1:0]       drop_cnt;
    logic [CNT_W-1:0]       bad_cnt;
    logic                   err_sticky;
    logic [1:0]             fifo_state;

    always #5 clk = ~clk;

    switch_port_egress_rx_if #(.DATA_W(DATA_W)) bus ();

    switch_port_egress_rx #(
        .PORT_ID(PORT_ID), .DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_stats  (clr_stats),
        .fifo_level (fifo_level),
        .pkt_cnt    (pkt_cnt),
        .drop_cnt   (drop_cnt),
        .bad_cnt    (bad_cnt),
        .err_sticky (err_sticky),
        .fifo_state (fifo_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int m_level;
    int m_pkt[4];
    int m_drop;
    int m_bad;
    int m_sticky;
    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic logic [1:0] idx_of(input logic [3:0] s);
        logic [1:0] r = 2'd0;
        for (int i = 0; i < 4; i++) if (s[i]) r = 2'(i);
        return r;
    endfunction

    // ---------------- reference model (posedge) ----------------
    always @(posedge clk) begin : model
        bit pop_m, bad_m, drop_m, acc_m;
        if (rst) begin
            m_level = 0;
            exp_q.delete();
            for (int i = 0; i < 4; i++) m_pkt[i] = 0;
            m_drop = 0; m_bad = 0; m_sticky = 0;
        end else begin
            pop_m = (m_level != 0) && bus.rx_ready;
            bad_m = 0; drop_m = 0; acc_m = 0;
            if (bus.sw_valid) begin
                if (bus.sw_target != OWN || $countones(bus.sw_source) != 1 ||
                    bus.sw_source == OWN)
                    bad_m = 1;
                else if (m_level == DEPTH && !pop_m)
                    drop_m = 1;
                else
                    acc_m = 1;
            end
            if (acc_m) exp_q.push_back({idx_of(bus.sw_source), bus.sw_data});
            m_level = m_level + int'(acc_m) - int'(pop_m);
            if (clr_stats) begin
                for (int i = 0; i < 4; i++) m_pkt[i] = 0;
                m_drop = 0; m_bad = 0; m_sticky = 0;
            end else begin
                if (acc_m) m_pkt[idx_of(bus.sw_source)] = sat(m_pkt[idx_of(bus.sw_source)]);
                if (drop_m) m_drop = sat(m_drop);
                if (bad_m) m_bad = sat(m_bad);
                if (bad_m || drop_m) m_sticky = 1;
            end
        end
    end

    // ---------------- monitor (negedge) ----------------
    always @(negedge clk) begin
        chk("rx_valid", 32'(bus.rx_valid), 32'(m_level != 0));
        chk("fifo_level", 32'(fifo_level), m_level);
        chk("fifo_state", 32'(fifo_state), (m_level == 0) ? 0 : (m_level == DEPTH) ? 2 : 1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("pkt_cnt[%0d]", i), 32'(pkt_cnt[i*CNT_W +: CNT_W]), m_pkt[i]);
        chk("drop_cnt", 32'(drop_cnt), m_drop);
        chk("bad_cnt", 32'(bad_cnt), m_bad);
        chk("err_sticky", 32'(err_sticky), m_sticky);
        if (m_level != 0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head: model level %0d but no expected entry", m_level);
            end else begin
                chk("head", 32'({bus.rx_source, bus.rx_data}), 32'(exp_q[0]));
                if (bus.rx_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
        bus.sw_valid  = 1'b1;
        bus.sw_source = s;
        bus.sw_target = t;
        bus.sw_data   = d;
        tick();
        bus.sw_valid  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        clr_stats = 1'b0;
        bus.sw_valid = 1'b0;
        bus.sw_source = 4'd0;
        bus.sw_target = 4'd0;
        bus.sw_data = 8'd0;
        bus.rx_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_rx_data", 32'(bus.rx_data), 0);
        chk("reset_rx_source", 32'(bus.rx_source), 0);
        chk("reset_rx_valid", 32'(bus.rx_valid), 0);

        // T1: single good packet, visible one cycle later
        send(4'b0001, OWN, 8'hAA);
        chk("t1_rx_valid", 32'(bus.rx_valid), 1);
        chk("t1_rx_source", 32'(bus.rx_source), 0);
        chk("t1_rx_data", 32'(bus.rx_data), 32'h0000_00AA);
        chk("t1_pkt_cnt0", 32'(pkt_cnt[CNT_W-1:0]), 1);
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;

        // T2: wrong target, multi-hot source, own source
        send(4'b0001, 4'b0100, 8'h11);
        send(4'b0011, OWN, 8'h22);
        send(4'b0010, OWN, 8'h33);
        chk("t2_bad_cnt", 32'(bad_cnt), 3);
        chk("t2_err_sticky", 32'(err_sticky), 1);
        chk("t2_rx_valid", 32'(bus.rx_valid), 0);

        // T3: overfill with no client
        for (int d = 1; d <= 6; d++) send(4'b0001, OWN, 8'(d));
        chk("t3_level", 32'(fifo_level), 4);
        chk("t3_drop_cnt", 32'(drop_cnt), 2);

        // T4: full + pop + accept together
        bus.rx_ready = 1'b1;
        send(4'b0100, OWN, 8'h55);
        bus.rx_ready = 1'b0;
        chk("t4_level", 32'(fifo_level), 4);
        chk("t4_drop_cnt", 32'(drop_cnt), 2);
        chk("t4_head", 32'(bus.rx_data), 2);
        bus.rx_ready = 1'b1;
        repeat (5) tick();
        bus.rx_ready = 1'b0;
        chk("t4_drained", 32'(fifo_level), 0);

        // T5: back-to-back alternating sources with a ready client
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 10; i++) send((i % 2) ? 4'b0100 : 4'b0001, OWN, 8'(8'h10 + i));
        tick();
        bus.rx_ready = 1'b0;
        chk("t5_pkt_cnt0", 32'(pkt_cnt[0*CNT_W +: CNT_W]), 5);
        chk("t5_pkt_cnt2", 32'(pkt_cnt[2*CNT_W +: CNT_W]), 5);
        chk("t5_drop_cnt", 32'(drop_cnt), 0);

        // T6: clear with a same-cycle good packet, then reset mid-stream
        send(4'b1000, OWN, 8'h61);
        send(4'b0001, OWN, 8'h62);
        clr_stats = 1'b1;
        send(4'b0100, OWN, 8'h63);
        clr_stats = 1'b0;
        chk("t6_pkt_cnt", 32'(pkt_cnt), 0);
        chk("t6_level", 32'(fifo_level), 3);
        rst = 1'b1;
        send(4'b0001, OWN, 8'h64);
        rst = 1'b0;
        chk("t6_rst_level", 32'(fifo_level), 0);
        chk("t6_rst_rx_valid", 32'(bus.rx_valid), 0);

        // Randomized traffic; ready probability varies by phase to reach full
        for (int n = 0; n < 600; n++) begin
            int r;
            bus.rx_ready  = ($urandom_range(0, 9) < ((n / 100) % 2 ? 8 : 2));
            clr_stats     = ($urandom_range(0, 199) == 0);
            rst           = ($urandom_range(0, 149) == 0);
            bus.sw_valid  = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            bus.sw_source = (r < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            bus.sw_target = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : OWN;
            bus.sw_data   = 8'($urandom_range(0, 255));
            tick();
        end
        bus.sw_valid = 1'b0;
        clr_stats = 1'b0;
        rst = 1'b0;
        bus.rx_ready = 1'b1;
        repeat (8) tick();
        chk("final_drained", 32'(fifo_level), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
